// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks a low column across the pad, debounces whole frames and
// reports a single confirmed key as a one-cycle event plus a held level.
module keypad_scan #(
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(STABLE_CNT + 1);

  localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
  localparam logic [CntW:0]   CntTarget = (CntW + 1)'(STABLE_CNT);
  localparam bit              AcceptNow = (STABLE_CNT == 1);

  typedef enum logic [1:0] {
    StIdle,
    StConfirm,
    StHeld
  } state_e;

  logic [3:0]      row_s1_q, row_s2_q;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [1:0]      acc_n_q, acc_n_d;
  logic [3:0]      acc_key_q, acc_key_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_down_q, key_down_d;

  logic            sample, frame_end, frame_key;
  logic [3:0]      col_closed;
  logic [2:0]      col_hits;
  logic [1:0]      col_row;
  logic [2:0]      tot_n;
  logic [1:0]      merged_n;
  logic [3:0]      merged_key;
  logic [CntW:0]   cnt_inc;

  assign col_out   = ~(4'b0001 << col_idx_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_down  = key_down_q;

  assign sample     = (div_cnt_q == DivLast);
  assign frame_end  = sample && (col_idx_q == 2'd3);
  assign col_closed = ~row_s2_q;
  assign cnt_inc    = {1'b0, cnt_q} + 1'b1;

  // Closures in the column being sampled; col_row ends on the lowest closed row.
  always_comb begin
    col_hits = '0;
    col_row  = '0;
    for (int r = 3; r >= 0; r--) begin
      if (col_closed[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
  end

  // Frame accumulator counts closures saturating at 2, so 2 means MULTI.
  always_comb begin
    tot_n      = {1'b0, acc_n_q} + ((col_hits > 3'd2) ? 3'd2 : col_hits);
    merged_n   = (tot_n >= 3'd2) ? 2'd2 : tot_n[1:0];
    merged_key = (acc_n_q == 2'd0 && col_hits == 3'd1) ? {col_row, col_idx_q} : acc_key_q;
    frame_key  = frame_end && (merged_n == 2'd1);
  end

  always_comb begin
    div_cnt_d = sample ? '0 : div_cnt_q + 1'b1;
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
    acc_n_d   = acc_n_q;
    acc_key_d = acc_key_q;
    if (frame_end) begin
      acc_n_d   = '0;
      acc_key_d = '0;
    end else if (sample) begin
      acc_n_d   = merged_n;
      acc_key_d = merged_key;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (frame_key) begin
            cand_d = merged_key;
            if (AcceptNow) begin
              key_code_d  = merged_key;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              cnt_d       = '0;
              state_d     = StHeld;
            end else begin
              cnt_d   = CntW'(1);
              state_d = StConfirm;
            end
          end
        end
        StConfirm: begin
          if (!frame_key) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else if (merged_key != cand_q) begin
            cand_d = merged_key;
            cnt_d  = CntW'(1);
          end else if (cnt_inc >= CntTarget) begin
            key_code_d  = cand_q;
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            cnt_d       = '0;
            state_d     = StHeld;
          end else begin
            cnt_d = cnt_inc[CntW-1:0];
          end
        end
        StHeld: begin
          // Any key while held only restarts the release count: no repeat, no second event.
          if (frame_key) begin
            cnt_d = '0;
          end else if (cnt_inc >= CntTarget) begin
            key_down_d = 1'b0;
            cnt_d      = '0;
            state_d    = StIdle;
          end else begin
            cnt_d = cnt_inc[CntW-1:0];
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      div_cnt_q   <= '0;
      col_idx_q   <= '0;
      acc_n_q     <= '0;
      acc_key_q   <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      row_s1_q    <= row_in;
      row_s2_q    <= row_s1_q;
      div_cnt_q   <= div_cnt_d;
      col_idx_q   <= col_idx_d;
      acc_n_q     <= acc_n_d;
      acc_key_q   <= acc_key_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

endmodule
